memory_access: RTL

MEMORY_ACCESS -- requirements
Module: memory_access

---
 rtl/memory_access.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/memory_access.sv
// memory_access: single-outstanding load/store unit between execute and a valid/ready memory bus.
// Optional misaligned-access trap is enabled by defining MEMORY_ACCESS_MISALIGN_TRAP_EN.

module memory_access (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [31:0] execute_i_valE,
    input  logic [31:0] decode_i_reg_valB,
    input  logic        decode_i_mem_ren,
    input  logic        decode_i_mem_wen,
    input  logic [2:0]  decode_i_mem_func,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    output logic        mem_req_wen,
    output logic [31:0] mem_req_wdata,
    output logic [3:0]  mem_req_wmask,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_rdata,
    output logic [31:0] memory_o_valM,
    output logic        memory_o_done,
    output logic        memory_o_busy,
    output logic        memory_o_misalign
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] val_e_q, val_e_d;
    logic [31:0] val_b_q, val_b_d;
    logic [31:0] val_m_q, val_m_d;
    logic [2:0]  func_q, func_d;
    logic        ren_q, ren_d;
    logic        wen_q, wen_d;
    logic        misalign_q, misalign_d;

    logic        is_mem;
    logic        misalign_in;
    logic [1:0]  acc_size;
    logic        sign_ext;
    logic [1:0]  lane_off;
    logic [15:0] shifted;
    logic [31:0] load_data;
    logic [31:0] store_data;
    logic [3:0]  store_mask;

    // 0 = byte, 1 = halfword, 2 = word; unused funct3 codes fall back to word
    function automatic logic [1:0] access_size(input logic [2:0] f);
        case (f)
            3'b000, 3'b100: access_size = 2'd0;
            3'b001, 3'b101: access_size = 2'd1;
            default:        access_size = 2'd2;
        endcase
    endfunction

    assign is_mem = decode_i_mem_ren | decode_i_mem_wen;

`ifdef MEMORY_ACCESS_MISALIGN_TRAP_EN
    always_comb begin
        misalign_in = 1'b0;
        case (access_size(decode_i_mem_func))
            2'd1:    misalign_in = is_mem & execute_i_valE[0];
            2'd2:    misalign_in = is_mem & (|execute_i_valE[1:0]);
            default: misalign_in = 1'b0;
        endcase
    end
`else
    assign misalign_in = 1'b0;
`endif

    assign acc_size = access_size(func_q);
    assign sign_ext = ~func_q[2];

    always_comb begin
        store_mask = 4'b1111;
        store_data = val_b_q;
        lane_off   = 2'b00;
        case (acc_size)
            2'd0: begin
                store_mask = 4'b0001 << val_e_q[1:0];
                store_data = {4{val_b_q[7:0]}};
                lane_off   = val_e_q[1:0];
            end
            2'd1: begin
                store_mask = 4'b0011 << {val_e_q[1], 1'b0};
                store_data = {2{val_b_q[15:0]}};
                lane_off   = {val_e_q[1], 1'b0};
            end
            default: begin
                store_mask = 4'b1111;
                store_data = val_b_q;
                lane_off   = 2'b00;
            end
        endcase
    end

    // Bring the addressed lane down to bit 0, then widen by size and signedness
    always_comb begin
        shifted   = 16'(mem_rsp_rdata >> {lane_off, 3'b000});
        load_data = mem_rsp_rdata;
        case (acc_size)
            2'd0:    load_data = sign_ext ? {{24{shifted[7]}}, shifted[7:0]}
                                          : {24'h000000, shifted[7:0]};
            2'd1:    load_data = sign_ext ? {{16{shifted[15]}}, shifted[15:0]}
                                          : {16'h0000, shifted[15:0]};
            default: load_data = mem_rsp_rdata;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        val_e_d    = val_e_q;
        val_b_d    = val_b_q;
        val_m_d    = val_m_q;
        func_d     = func_q;
        ren_d      = ren_q;
        wen_d      = wen_q;
        misalign_d = misalign_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    val_e_d    = execute_i_valE;
                    val_b_d    = decode_i_reg_valB;
                    func_d     = decode_i_mem_func;
                    ren_d      = decode_i_mem_ren;
                    wen_d      = decode_i_mem_wen;
                    misalign_d = misalign_in;
                    if (misalign_in) begin
                        state_d = S_DONE;
                        val_m_d = 32'h0;
                    end else if (is_mem) begin
                        state_d = S_REQ;
                    end else begin
                        state_d = S_DONE;
                        val_m_d = execute_i_valE;
                    end
                end
            end
            S_REQ: begin
                if (mem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rsp_valid) begin
                    state_d = S_DONE;
                    val_m_d = ren_q ? load_data : 32'h0;
                end
            end
            S_DONE: begin
                state_d    = S_IDLE;
                misalign_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            val_e_q    <= 32'h0;
            val_b_q    <= 32'h0;
            val_m_q    <= 32'h0;
            func_q     <= 3'b000;
            ren_q      <= 1'b0;
            wen_q      <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            val_e_q    <= val_e_d;
            val_b_q    <= val_b_d;
            val_m_q    <= val_m_d;
            func_q     <= func_d;
            ren_q      <= ren_d;
            wen_q      <= wen_d;
            misalign_q <= misalign_d;
        end
    end

    assign mem_req_valid     = (state_q == S_REQ);
    assign mem_req_addr      = {val_e_q[31:2], 2'b00};
    assign mem_req_wen       = wen_q;
    assign mem_req_wdata     = store_data;
    assign mem_req_wmask     = store_mask;
    assign memory_o_valM     = val_m_q;
    assign memory_o_done     = (state_q == S_DONE);
    assign memory_o_busy     = (state_q != S_IDLE);
    assign memory_o_misalign = misalign_q;

endmodule
